// File: rtl/if_stage_ctrl_if.sv
// if_stage_ctrl_if: fetch-stage bus between hazard/EX/imem (master) and the fetch controller (slave).
interface if_stage_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic [XLEN-1:0]  imem_addr;
    logic [31:0]      imem_rdata;
    logic [XLEN-1:0]  IF_ID_PC;
    logic [31:0]      IF_ID_Instr;
    logic             IF_ID_Valid;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output PCWrite, IF_ID_Write, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, IF_ID_PC, IF_ID_Instr, IF_ID_Valid, stall_count, flush_count
    );

    modport slave (
        input  PCWrite, IF_ID_Write, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, IF_ID_PC, IF_ID_Instr, IF_ID_Valid, stall_count, flush_count
    );
endinterface

// File: rtl/if_stage_ctrl.sv
// if_stage_ctrl: PC and IF/ID register with hazard freeze, EX redirect flush and saturating perf counters.
module if_stage_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
    parameter int              CNT_W     = 16
) (
    input logic            clk,
    input logic            rst_n,
    if_stage_ctrl_if.slave bus
);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_RST     = RESET_PC & ALIGN_MASK;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  if_id_pc_q, if_id_pc_d;
    logic [31:0]      if_id_instr_q, if_id_instr_d;
    logic             if_id_valid_q, if_id_valid_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             flush, hold;

    always_comb begin
        flush = bus.redirect_valid;
        hold  = !bus.IF_ID_Write && !flush;
        pc_d  = flush ? (bus.redirect_pc & ALIGN_MASK) : bus.PCWrite ? pc_q + XLEN'(4) : pc_q;
        // flush beats hold, so a stalled ID slot is still squashed by a redirect
        if_id_pc_d    = flush ? '0 : hold ? if_id_pc_q : pc_q;
        if_id_instr_d = flush ? NOP_INSTR : hold ? if_id_instr_q : bus.imem_rdata;
        if_id_valid_d = flush ? 1'b0 : hold ? if_id_valid_q : 1'b1;
        stall_count_d = (hold && !(&stall_count_q)) ? stall_count_q + CNT_W'(1) : stall_count_q;
        flush_count_d = (flush && !(&flush_count_q)) ? flush_count_q + CNT_W'(1) : flush_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= PC_RST;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.IF_ID_PC    = if_id_pc_q;
    assign bus.IF_ID_Instr = if_id_instr_q;
    assign bus.IF_ID_Valid = if_id_valid_q;
    assign bus.stall_count = stall_count_q;
    assign bus.flush_count = flush_count_q;
endmodule

// File: tb/tb_if_stage_ctrl.sv
// tb_if_stage_ctrl: directed and randomized checks of if_stage_ctrl against a cycle-level reference model.
module tb_if_stage_ctrl;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_stage_ctrl_if #(.XLEN(32), .CNT_W(16)) b ();
    if_stage_ctrl_if #(.XLEN(32), .CNT_W(2))  s ();

    if_stage_ctrl #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b)
    );
    if_stage_ctrl #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(s)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        case (a)
            32'h0:   instr_of = 32'h00A0_0093;
            32'h4:   instr_of = 32'h00B0_0113;
            32'h8:   instr_of = 32'h00C0_0193;
            default: instr_of = (a * 32'd2654435761) ^ 32'h5A5A_0013;
        endcase
    endfunction

    assign b.imem_rdata = instr_of(b.imem_addr);
    assign s.imem_rdata = 32'h0;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] m_pc, m_ipc, m_instr;
    logic        m_valid;
    logic [15:0] m_stall, m_flush;

    task automatic model_reset();
        m_pc = 0; m_ipc = 0; m_instr = NOP; m_valid = 0; m_stall = 0; m_flush = 0;
    endtask

    // What the fetch stage should hold after one edge, from the current inputs.
    task automatic model_step();
        if (b.redirect_valid) begin
            if (m_flush != 16'hFFFF) m_flush = m_flush + 1;
            m_ipc = 0; m_instr = NOP; m_valid = 0;
            m_pc = {b.redirect_pc[31:2], 2'b00};
        end else begin
            if (!b.IF_ID_Write) begin
                if (m_stall != 16'hFFFF) m_stall = m_stall + 1;
            end else begin
                m_ipc = m_pc; m_instr = instr_of(m_pc); m_valid = 1;
            end
            if (b.PCWrite) m_pc = m_pc + 4;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pcw, input logic ifw, input logic rv, input logic [31:0] rpc);
        b.PCWrite = pcw; b.IF_ID_Write = ifw; b.redirect_valid = rv; b.redirect_pc = rpc;
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 0);
        s.PCWrite = 1; s.IF_ID_Write = 1; s.redirect_valid = 0; s.redirect_pc = 0;
        model_reset();
        #3;
        n_checks++; if (b.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc_async got %h exp %h", b.imem_addr, 32'h0); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (b.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", b.imem_addr, 32'h0); end
        n_checks++; if (b.IF_ID_Instr !== NOP) begin n_fail++; $display("FAIL reset_instr got %h exp %h", b.IF_ID_Instr, NOP); end
        n_checks++; if (b.IF_ID_Valid !== 1'b0 || b.IF_ID_PC !== 32'h0) begin n_fail++; $display("FAIL reset_ifid got v=%b pc=%h exp v=0 pc=0", b.IF_ID_Valid, b.IF_ID_PC); end
        n_checks++; if (b.stall_count !== 16'h0 || b.flush_count !== 16'h0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d exp 0/0", b.stall_count, b.flush_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential_fetch();
        logic [31:0] exp_instr [3];
        exp_instr[0] = 32'h00A0_0093; exp_instr[1] = 32'h00B0_0113; exp_instr[2] = 32'h00C0_0193;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (b.imem_addr !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL seq_pc[%0d] got %h exp %h", i, b.imem_addr, 32'(4 * (i + 1))); end
            n_checks++; if (b.IF_ID_PC !== 32'(4 * i) || b.IF_ID_Instr !== exp_instr[i] || b.IF_ID_Valid !== 1'b1) begin
                n_fail++; $display("FAIL seq_ifid[%0d] got pc=%h ins=%h v=%b exp pc=%h ins=%h v=1", i, b.IF_ID_PC, b.IF_ID_Instr, b.IF_ID_Valid, 32'(4 * i), exp_instr[i]);
            end
        end
    endtask

    task automatic test_stall();
        drive(1, 1, 0, 0);
        tick();
        n_checks++; if (b.imem_addr !== 32'h10) begin n_fail++; $display("FAIL stall_pre_pc got %h exp %h", b.imem_addr, 32'h10); end
        drive(0, 0, 0, 0);
        repeat (2) tick();
        n_checks++; if (b.imem_addr !== 32'h10 || b.IF_ID_PC !== 32'hC) begin n_fail++; $display("FAIL stall_hold got pc=%h ifid_pc=%h exp 10/c", b.imem_addr, b.IF_ID_PC); end
        n_checks++; if (b.stall_count !== 16'd2) begin n_fail++; $display("FAIL stall_count got %0d exp 2", b.stall_count); end
        drive(1, 1, 0, 0);
        tick();
        n_checks++; if (b.IF_ID_PC !== 32'h10 || b.imem_addr !== 32'h14) begin n_fail++; $display("FAIL stall_release got ifid_pc=%h pc=%h exp 10/14", b.IF_ID_PC, b.imem_addr); end
        drive(1, 0, 0, 0);
        tick();
        n_checks++; if (b.imem_addr !== 32'h18 || b.IF_ID_PC !== 32'h10 || b.stall_count !== 16'd3) begin
            n_fail++; $display("FAIL stall_mismatch got pc=%h ifid_pc=%h cnt=%0d exp 18/10/3", b.imem_addr, b.IF_ID_PC, b.stall_count);
        end
    endtask

    task automatic test_redirect();
        drive(1, 1, 1, 32'h100);
        tick();
        n_checks++; if (b.imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_pc got %h exp %h", b.imem_addr, 32'h100); end
        n_checks++; if (b.IF_ID_Instr !== NOP || b.IF_ID_Valid !== 1'b0 || b.IF_ID_PC !== 32'h0) begin
            n_fail++; $display("FAIL redir_flush got ins=%h v=%b pc=%h exp %h/0/0", b.IF_ID_Instr, b.IF_ID_Valid, b.IF_ID_PC, NOP);
        end
        n_checks++; if (b.flush_count !== 16'd1) begin n_fail++; $display("FAIL redir_flush_count got %0d exp 1", b.flush_count); end
        drive(1, 1, 0, 0);
        tick();
        n_checks++; if (b.IF_ID_PC !== 32'h100 || b.IF_ID_Valid !== 1'b1 || b.imem_addr !== 32'h104) begin
            n_fail++; $display("FAIL redir_follow got ifid_pc=%h v=%b pc=%h exp 100/1/104", b.IF_ID_PC, b.IF_ID_Valid, b.imem_addr);
        end
    endtask

    task automatic test_redirect_stall();
        drive(0, 0, 1, 32'h203);
        tick();
        n_checks++; if (b.imem_addr !== 32'h200) begin n_fail++; $display("FAIL rs_pc got %h exp %h", b.imem_addr, 32'h200); end
        n_checks++; if (b.IF_ID_Valid !== 1'b0 || b.IF_ID_Instr !== NOP) begin n_fail++; $display("FAIL rs_flush got v=%b ins=%h exp 0/%h", b.IF_ID_Valid, b.IF_ID_Instr, NOP); end
        n_checks++; if (b.flush_count !== 16'd2 || b.stall_count !== 16'd3) begin n_fail++; $display("FAIL rs_counts got s=%0d f=%0d exp 3/2", b.stall_count, b.flush_count); end
    endtask

    task automatic test_wrap();
        drive(1, 1, 1, 32'hFFFF_FFFC);
        tick();
        n_checks++; if (b.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre got %h exp fffffffc", b.imem_addr); end
        drive(1, 1, 0, 0);
        tick();
        n_checks++; if (b.imem_addr !== 32'h0 || b.IF_ID_PC !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap got pc=%h ifid_pc=%h exp 0/fffffffc", b.imem_addr, b.IF_ID_PC); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), $urandom);
            tick();
            n_checks++;
            if (b.imem_addr !== m_pc || b.IF_ID_PC !== m_ipc || b.IF_ID_Instr !== m_instr || b.IF_ID_Valid !== m_valid
                || b.stall_count !== m_stall || b.flush_count !== m_flush) begin
                n_fail++;
                $display("FAIL random[%0d] got pc=%h ipc=%h ins=%h v=%b s=%0d f=%0d exp pc=%h ipc=%h ins=%h v=%b s=%0d f=%0d",
                         i, b.imem_addr, b.IF_ID_PC, b.IF_ID_Instr, b.IF_ID_Valid, b.stall_count, b.flush_count,
                         m_pc, m_ipc, m_instr, m_valid, m_stall, m_flush);
            end
        end
    endtask

    task automatic test_saturation_and_async_reset();
        logic [1:0] exp_sat;
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s.IF_ID_Write = 1'b0;
        drive(0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_sat = (i < 3) ? 2'(i) : 2'd3;
            n_checks++; if (s.stall_count !== exp_sat) begin n_fail++; $display("FAIL sat[%0d] got %0d exp %0d", i, s.stall_count, exp_sat); end
        end
        n_checks++; if (b.stall_count !== m_stall) begin n_fail++; $display("FAIL sat_main got %0d exp %0d", b.stall_count, m_stall); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (s.stall_count !== 2'd0 || b.stall_count !== 16'd0) begin n_fail++; $display("FAIL async_counts got %0d/%0d exp 0/0", s.stall_count, b.stall_count); end
        n_checks++; if (b.imem_addr !== 32'h0 || b.IF_ID_PC !== 32'h0 || b.IF_ID_Instr !== NOP || b.IF_ID_Valid !== 1'b0 || b.flush_count !== 16'd0) begin
            n_fail++; $display("FAIL async_regs got pc=%h ipc=%h ins=%h v=%b f=%0d exp 0/0/%h/0/0", b.imem_addr, b.IF_ID_PC, b.IF_ID_Instr, b.IF_ID_Valid, b.flush_count, NOP);
        end
    endtask

    initial begin
        test_reset();
        test_sequential_fetch();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_random();
        test_saturation_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage_ctrl.md
Name: if_stage_ctrl

Overview:
Fetch-side counterpart of the load-use hazard unit. It owns the PC register and the IF/ID pipeline register and consumes PCWrite and IF_ID_Write to freeze fetch. It accepts branch/jump redirects from EX and flushes IF/ID to a NOP bubble. It also keeps saturating stall and flush counters for performance debug.

Parameters:
XLEN, 32, PC and address width
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)
CNT_W, 16, width of the stall and flush counters

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
PCWrite  input  1  1 = PC may advance; 0 = hold PC (from hazard unit)
IF_ID_Write  input  1  1 = IF/ID may load; 0 = hold IF/ID (from hazard unit)
redirect_valid  input  1  taken branch/jump resolved in EX
redirect_pc  input  XLEN  redirect target
imem_addr  output  XLEN  instruction memory address, combinational = PC
imem_rdata  input  32  instruction word for imem_addr, same cycle (combinational imem)
IF_ID_PC  output  XLEN  registered PC of the instruction in ID
IF_ID_Instr  output  32  registered instruction in ID
IF_ID_Valid  output  1  1 = IF_ID_Instr is a real instruction
stall_count  output  CNT_W  saturating count of IF/ID hold cycles
flush_count  output  CNT_W  saturating count of redirects

Behaviour:
- Reset is asynchronous and active-low: one clock, clk; reset rst_n, asynchronous, active-low. While rst_n=0: PC=RESET_PC, IF_ID_PC=0, IF_ID_Instr=NOP_INSTR, IF_ID_Valid=0, stall_count=0, flush_count=0. Deassertion takes effect at the next rising edge, and fetch of RESET_PC starts that cycle.
- imem_addr = PC at all times. PC bits [1:0] are always 0.
- PC next-state, in priority order:
  - redirect_valid=1: PC <= {redirect_pc[XLEN-1:2],2'b00}. The low bits are forced to 0 and no misalignment error is raised.
  - PCWrite=0: PC holds.
  - Otherwise: PC <= PC+4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
- IF/ID next-state, in priority order:
  - redirect_valid=1 (flush): IF_ID_Instr<=NOP_INSTR, IF_ID_Valid<=0, IF_ID_PC<=0. Flush overrides IF_ID_Write=0.
  - IF_ID_Write=0: all IF/ID fields hold.
  - Otherwise: IF_ID_PC<=PC, IF_ID_Instr<=imem_rdata, IF_ID_Valid<=1.
- Fetch-to-ID latency is 1 cycle: the instruction at PC appears on IF_ID_* at the next rising edge.
- PCWrite and IF_ID_Write are acted on independently. A mismatch (e.g. PCWrite=1, IF_ID_Write=0) is legal: the PC advances and the held IF/ID entry is kept; the skipped fetch is the caller's responsibility.
- Counters, each updated once per rising edge:
  - stall_count +1 when IF_ID_Write=0 and redirect_valid=0.
  - flush_count +1 when redirect_valid=1.
  - Both saturate at 2^CNT_W-1 and never wrap. They clear only on reset.
- Same-cycle redirect and stall: the redirect wins for both PC and IF/ID, only flush_count increments, and the PC loads the target.
- Reset asserted mid-stall or mid-redirect: every register returns to its reset value immediately, without waiting for a clock edge.
- No combinational path exists from any input to IF_ID_* or to the counters. imem_addr depends only on the PC register.

Test Plan:
1. Reset, then 3 cycles with PCWrite=IF_ID_Write=1 and imem_rdata = 0x00A00093/0x00B00113/0x00C00193 -> imem_addr steps 0,4,8,C. IF_ID_PC/Instr lag by one cycle (0/0x00A00093, then 4/0x00B00113, ...). IF_ID_Valid=1 from the first edge after reset release.
2. With PC=8, drive PCWrite=IF_ID_Write=0 for 2 cycles -> PC stays 8, IF_ID_PC stays 4, stall_count=2. Fetch of 8 is captured on the first edge after release.
3. redirect_valid=1, redirect_pc=0x100 -> next cycle PC=0x100, IF_ID_Instr=0x00000013, IF_ID_Valid=0, flush_count=1. The following edge loads IF_ID_PC=0x100.
4. redirect_valid=1 with PCWrite=IF_ID_Write=0 and redirect_pc=0x203 -> PC=0x200, IF/ID flushed, flush_count+1, stall_count unchanged.
5. Redirect to 0xFFFFFFFC, then one free-running cycle -> PC wraps to 0x00000000.
6. CNT_W=2, hold IF_ID_Write=0 for 5 cycles -> stall_count reads 1,2,3,3,3. Assert rst_n=0 mid-stall -> all outputs return to reset values with no clock edge.
